// File: rtl/isp_ccm_pkg.sv
// isp_ccm_pkg -- shared constants for the colour correction matrix stage.
//   Register address map of the configuration port, pipeline latency of the
//   datapath and the unity coefficient value for a given fractional width.
//   Offset addresses are only decoded when ISP_CCM_OFFSET_EN is defined.
package isp_ccm_pkg;

  localparam logic [3:0] ADDR_M00   = 4'd0;
  localparam logic [3:0] ADDR_M01   = 4'd1;
  localparam logic [3:0] ADDR_M02   = 4'd2;
  localparam logic [3:0] ADDR_M10   = 4'd3;
  localparam logic [3:0] ADDR_M11   = 4'd4;
  localparam logic [3:0] ADDR_M12   = 4'd5;
  localparam logic [3:0] ADDR_M20   = 4'd6;
  localparam logic [3:0] ADDR_M21   = 4'd7;
  localparam logic [3:0] ADDR_M22   = 4'd8;
  localparam logic [3:0] ADDR_CTRL  = 4'd9;
  localparam logic [3:0] ADDR_OFS_R = 4'd10;
  localparam logic [3:0] ADDR_OFS_G = 4'd11;
  localparam logic [3:0] ADDR_OFS_B = 4'd12;

  localparam int CCM_LATENCY = 3;
  localparam int CCM_NCOEF   = 9;

  // Coefficient value representing 1.0 for a given number of fractional bits.
  function automatic int ccm_unity(input int frac);
    return 1 << frac;
  endfunction

endpackage

// File: rtl/isp_ccm_dot3.sv
// isp_ccm_dot3 -- one matrix row: y = clamp((m0*x0 + m1*x1 + m2*x2
//   [+ ofs<<FRAC] + 2^(FRAC-1)) >>> FRAC), three register stages.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   m0..m2          signed row coefficients, sampled with the pixel
//   x0..x2          unsigned input components (R, G, B)
//   ofs             signed row offset (only with ISP_CCM_OFFSET_EN)
//   y               clamped output component, valid 3 cycles after input
module isp_ccm_dot3 #(
  parameter int BITS      = 8,
  parameter int COEF_BITS = 12,
  parameter int FRAC      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [COEF_BITS-1:0] m0,
  input  logic signed [COEF_BITS-1:0] m1,
  input  logic signed [COEF_BITS-1:0] m2,
  input  logic        [BITS-1:0]      x0,
  input  logic        [BITS-1:0]      x1,
  input  logic        [BITS-1:0]      x2,
`ifdef ISP_CCM_OFFSET_EN
  input  logic signed [COEF_BITS-1:0] ofs,
`endif
  output logic        [BITS-1:0]      y
);

  localparam int PW = BITS + COEF_BITS + 1;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = SW'((1 << BITS) - 1);

  // Unsigned pixel is zero-extended by one bit so it multiplies as signed.
  function automatic logic signed [PW-1:0] mul(input logic signed [COEF_BITS-1:0] m,
                                               input logic        [BITS-1:0]      x);
    logic signed [PW-1:0] ms;
    logic signed [PW-1:0] xs;
    ms = PW'(m);
    xs = PW'($signed({1'b0, x}));
    return ms * xs;
  endfunction

  // Rounding constant is already in acc; floor shift then saturate.
  function automatic logic [BITS-1:0] shift_clamp(input logic signed [SW-1:0] acc);
    logic signed [SW-1:0] sh;
    sh = acc >>> FRAC;
    if (sh < 0)    return '0;
    if (sh > MAXV) return '1;
    return sh[BITS-1:0];
  endfunction

  logic signed [PW-1:0] prod_p0 [3];
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] sum_p1;
  logic        [BITS-1:0] y_p2;
`ifdef ISP_CCM_OFFSET_EN
  logic signed [COEF_BITS-1:0] ofs_p0;
`endif

  always_comb begin
    sum_d = SW'(prod_p0[0]) + SW'(prod_p0[1]) + SW'(prod_p0[2]) + RND;
`ifdef ISP_CCM_OFFSET_EN
    sum_d = sum_d + (SW'(ofs_p0) <<< FRAC);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) prod_p0[k] <= '0;
      sum_p1 <= '0;
      y_p2   <= '0;
`ifdef ISP_CCM_OFFSET_EN
      ofs_p0 <= '0;
`endif
    end else begin
      // S1: products (offset travels with the pixel it belongs to)
      prod_p0[0] <= mul(m0, x0);
      prod_p0[1] <= mul(m1, x1);
      prod_p0[2] <= mul(m2, x2);
`ifdef ISP_CCM_OFFSET_EN
      ofs_p0     <= ofs;
`endif
      // S2: row sum with rounding constant
      sum_p1 <= sum_d;
      // S3: shift and clamp
      y_p2   <= shift_clamp(sum_p1);
    end
  end

  assign y = y_p2;

endmodule

// File: rtl/isp_ccm.sv
// isp_ccm -- colour correction matrix stage after demosaic.
//   Applies a programmable signed 3x3 matrix (1.0 = 2^FRAC) to each RGB pixel,
//   rounds and clamps, and delays href/vsync by 3 cycles to match. Config
//   writes go to pending registers that are copied to the active set on a
//   vsync rising edge, so a frame never sees mixed coefficients.
//   Optional feature macro: ISP_CCM_OFFSET_EN (per-channel offsets, addr 10..12).
// Ports:
//   pclk, rst                   clock, synchronous active-high reset
//   in_href, in_vsync           input timing
//   in_r, in_g, in_b            input pixel
//   cfg_wr, cfg_addr, cfg_wdata config write port (pending registers)
//   cfg_rdata                   combinational pending-register readback
//   out_href, out_vsync         timing delayed by 3
//   out_r, out_g, out_b         corrected pixel, 0 while out_href is low
module isp_ccm import isp_ccm_pkg::*; #(
  parameter int BITS      = 8,
  parameter int COEF_BITS = 12,
  parameter int FRAC      = 8
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 in_href,
  input  logic                 in_vsync,
  input  logic [BITS-1:0]      in_r,
  input  logic [BITS-1:0]      in_g,
  input  logic [BITS-1:0]      in_b,
  input  logic                 cfg_wr,
  input  logic [3:0]           cfg_addr,
  input  logic [COEF_BITS-1:0] cfg_wdata,
  output logic [COEF_BITS-1:0] cfg_rdata,
  output logic                 out_href,
  output logic                 out_vsync,
  output logic [BITS-1:0]      out_r,
  output logic [BITS-1:0]      out_g,
  output logic [BITS-1:0]      out_b
);

  localparam logic signed [COEF_BITS-1:0] UNITY = COEF_BITS'(ccm_unity(FRAC));

  logic signed [COEF_BITS-1:0] pend_q   [CCM_NCOEF];
  logic signed [COEF_BITS-1:0] act_q    [CCM_NCOEF];
  logic signed [COEF_BITS-1:0] coef_eff [CCM_NCOEF];
  logic byp_pend_q, byp_act_q, byp_eff;
  logic vsync_prev_q;
  logic commit;
`ifdef ISP_CCM_OFFSET_EN
  logic signed [COEF_BITS-1:0] ofs_pend_q [3];
  logic signed [COEF_BITS-1:0] ofs_act_q  [3];
  logic signed [COEF_BITS-1:0] ofs_eff    [3];
`endif

  assign commit = in_vsync & ~vsync_prev_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int k = 0; k < CCM_NCOEF; k++) begin
        pend_q[k] <= (k % 4 == 0) ? UNITY : '0;
        act_q[k]  <= (k % 4 == 0) ? UNITY : '0;
      end
      byp_pend_q   <= 1'b0;
      byp_act_q    <= 1'b0;
      vsync_prev_q <= 1'b0;
`ifdef ISP_CCM_OFFSET_EN
      for (int k = 0; k < 3; k++) begin
        ofs_pend_q[k] <= '0;
        ofs_act_q[k]  <= '0;
      end
`endif
    end else begin
      vsync_prev_q <= in_vsync;
      // Commit copies the pending set as it stood before this cycle's write.
      if (commit) begin
        for (int k = 0; k < CCM_NCOEF; k++) act_q[k] <= pend_q[k];
        byp_act_q <= byp_pend_q;
`ifdef ISP_CCM_OFFSET_EN
        for (int k = 0; k < 3; k++) ofs_act_q[k] <= ofs_pend_q[k];
`endif
      end
      if (cfg_wr) begin
        if (cfg_addr <= ADDR_M22) pend_q[cfg_addr] <= cfg_wdata;
        else if (cfg_addr == ADDR_CTRL) byp_pend_q <= cfg_wdata[0];
`ifdef ISP_CCM_OFFSET_EN
        else if (cfg_addr == ADDR_OFS_R) ofs_pend_q[0] <= cfg_wdata;
        else if (cfg_addr == ADDR_OFS_G) ofs_pend_q[1] <= cfg_wdata;
        else if (cfg_addr == ADDR_OFS_B) ofs_pend_q[2] <= cfg_wdata;
`endif
      end
    end
  end

  // Pixels sampled in the commit cycle already use the incoming set.
  always_comb begin
    for (int k = 0; k < CCM_NCOEF; k++) coef_eff[k] = commit ? pend_q[k] : act_q[k];
    byp_eff = commit ? byp_pend_q : byp_act_q;
`ifdef ISP_CCM_OFFSET_EN
    for (int k = 0; k < 3; k++) ofs_eff[k] = commit ? ofs_pend_q[k] : ofs_act_q[k];
`endif
  end

  always_comb begin
    cfg_rdata = '0;
    if (cfg_addr <= ADDR_M22) cfg_rdata = pend_q[cfg_addr];
    else if (cfg_addr == ADDR_CTRL) cfg_rdata = {{(COEF_BITS-1){1'b0}}, byp_pend_q};
`ifdef ISP_CCM_OFFSET_EN
    else if (cfg_addr == ADDR_OFS_R) cfg_rdata = ofs_pend_q[0];
    else if (cfg_addr == ADDR_OFS_G) cfg_rdata = ofs_pend_q[1];
    else if (cfg_addr == ADDR_OFS_B) cfg_rdata = ofs_pend_q[2];
`endif
  end

  logic [CCM_LATENCY-1:0] href_p, vsync_p, byp_p;
  logic [3*BITS-1:0]      pix_p [CCM_LATENCY];

  // Timing, bypass flag and raw pixel delay lines, 3 deep
  always_ff @(posedge pclk) begin
    if (rst) begin
      href_p  <= '0;
      vsync_p <= '0;
      byp_p   <= '0;
      for (int k = 0; k < CCM_LATENCY; k++) pix_p[k] <= '0;
    end else begin
      href_p   <= {href_p[CCM_LATENCY-2:0], in_href};
      vsync_p  <= {vsync_p[CCM_LATENCY-2:0], in_vsync};
      byp_p    <= {byp_p[CCM_LATENCY-2:0], byp_eff};
      pix_p[0] <= {in_r, in_g, in_b};
      for (int k = 1; k < CCM_LATENCY; k++) pix_p[k] <= pix_p[k-1];
    end
  end

  logic [BITS-1:0] ccm_y [3];

  for (genvar i = 0; i < 3; i++) begin : g_row
    isp_ccm_dot3 #(
      .BITS      (BITS),
      .COEF_BITS (COEF_BITS),
      .FRAC      (FRAC)
    ) u_dot3 (
      .clk (pclk),
      .rst (rst),
      .m0  (coef_eff[3*i]),
      .m1  (coef_eff[3*i+1]),
      .m2  (coef_eff[3*i+2]),
      .x0  (in_r),
      .x1  (in_g),
      .x2  (in_b),
`ifdef ISP_CCM_OFFSET_EN
      .ofs (ofs_eff[i]),
`endif
      .y   (ccm_y[i])
    );
  end

  assign out_href  = href_p[CCM_LATENCY-1];
  assign out_vsync = vsync_p[CCM_LATENCY-1];

  always_comb begin
    out_r = '0;
    out_g = '0;
    out_b = '0;
    if (out_href) begin
      if (byp_p[CCM_LATENCY-1]) begin
        out_r = pix_p[CCM_LATENCY-1][3*BITS-1 -: BITS];
        out_g = pix_p[CCM_LATENCY-1][2*BITS-1 -: BITS];
        out_b = pix_p[CCM_LATENCY-1][BITS-1:0];
      end else begin
        out_r = ccm_y[0];
        out_g = ccm_y[1];
        out_b = ccm_y[2];
      end
    end
  end

endmodule

// File: doc/isp_ccm.md
Name: isp_ccm

Overview:
- Colour correction matrix stage, directly downstream of the demosaic stage.
- Takes the demosaic RGB pixel stream and timing (href/vsync) and applies a programmable 3x3 signed matrix.
- Rounds, clamps and emits corrected RGB with timing delayed to match.
- Coefficients are written via a simple config port into pending registers and become active only at a frame boundary (vsync rising edge), so a frame is never processed with mixed coefficients.

Parameters:
- BITS, 8, pixel component width.
- COEF_BITS, 12, signed coefficient width (two's complement).
- FRAC, 8, coefficient fractional bits; 1.0 = 2^FRAC = 256.

Ports:
- pclk  in  1  pixel clock; everything is synchronous to it.
- rst  in  1  reset, synchronous, active-high.
- in_href  in  1  line valid.
- in_vsync  in  1  frame sync, active-high.
- in_r / in_g / in_b  in  BITS each  input pixel.
- cfg_wr  in  1  write strobe, one cycle.
- cfg_addr  in  4  register address.
- cfg_wdata  in  COEF_BITS  write data.
- cfg_rdata  out  COEF_BITS  combinational readback of the pending register at cfg_addr; 0 for unmapped addresses.
- out_href  out  1  in_href delayed 3.
- out_vsync  out  1  in_vsync delayed 3.
- out_r / out_g / out_b  out  BITS each  corrected pixel.

Behaviour:
- Clock and reset: single clock pclk. Reset is synchronous, active-high.
- Address map (pending registers):
  - 0..8: m00 m01 m02 m10 m11 m12 m20 m21 m22, row-major.
  - Row i produces output i (R, G, B) from inputs (R, G, B).
  - 9: control; bit0 = bypass, other bits read 0.
  - 10..15: unmapped; writes ignored.
- Reset values: pending = active = identity (diagonal 256, off-diagonal 0), bypass 0. Pipeline registers, out_href, out_vsync and out_r/g/b all 0.
- Commit:
  - Frame boundary = in_vsync=1 while vsync_prev=0 (vsync_prev is a registered copy of in_vsync, reset 0).
  - On that cycle, active <= pending (all 10 registers atomically).
  - If cfg_wr occurs in the same cycle, the write lands in pending but is NOT included in this commit; it takes effect at the next frame.
  - Pixels sampled in the commit cycle already use the new active set.
- Datapath, 3 register stages, latency exactly 3 cycles from input to output:
  - S1: nine signed products p_ij = m_ij * {1'b0,in_j}, each BITS+COEF_BITS+1 bits signed.
  - S2: per-row sum of the three products plus rounding constant 2^(FRAC-1), widened by 2 bits.
  - S3: arithmetic shift right by FRAC; clamp negative to 0 and above 2^BITS-1 to 2^BITS-1.
- Bypass (active bit0=1): out_x = in_x delayed 3 cycles, bit-exact.
- Output gating: out_r/g/b are forced to 0 whenever out_href=0.
- Timing: out_href and out_vsync are pure 3-deep shift registers, independent of config.
- Reset mid-frame: all state returns to reset values, pending configuration is lost, and output stays 0 until 3 cycles after the first input with href=1.
- Throughput: one pixel per clock, no stalls, no backpressure.

Optional Feature:
- Macro: ISP_CCM_OFFSET_EN.
- When defined:
  - Adds pending/active registers 10, 11, 12 = signed per-channel offsets o_r, o_g, o_b, reset 0, same frame-boundary commit rule.
  - The offset is added in S2 as o_i << FRAC, before rounding and clamping.
  - Latency is unchanged.
- When not defined: addresses 10..12 are unmapped (read 0, writes ignored) and there are no offset adders.

Decomposition:
- Package isp_ccm_pkg holds:
  - address constants (ADDR_M00..ADDR_M22, ADDR_CTRL, ADDR_OFS_R/G/B);
  - CCM_LATENCY = 3;
  - the identity coefficient value (1 << FRAC).
- Sub-module isp_ccm_dot3: one row as a 3-stage pipelined dot product with round, offset and clamp. Instantiated 3 times.
- Config registers, commit logic, bypass and timing delay stay in the top level.

Test Plan (BITS=8, FRAC=8):
1. After reset, href=1, feed (100,150,200) -> (100,150,200) on out_r/g/b exactly 3 cycles later, with out_href high in that same cycle.
2. Mid-frame write m00=512 -> same-frame R=100 still gives 100. After the next vsync rising edge, R=100 gives 200 and R=200 clamps to 255. cfg_rdata at addr 0 reads 512 immediately after the write.
3. Row 0 set to m00=256, m01=-512 (0xE00), m02=0, then commit. Input (10,100,0) -> out_r=0 (negative clamp). Input (250,0,0) -> out_r=250.
4. Rounding: m00=128, commit. R=3 -> out_r=2 (1.5 rounds up). R=1 -> out_r=1 (0.5 rounds up).
5. cfg_wr m11=0 in the same cycle as the vsync rising edge -> G is unchanged for that frame and becomes 0 from the following frame. With href low, out_r/g/b read 0.
6. Bypass=1 with non-identity matrix, commit, then random pixels -> outputs bit-exact equal to inputs delayed 3. Assert rst mid-line -> all outputs 0 next cycle and identity restored.
